icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 No parameters; cache geometry is fixed by shared package constants (16 frames, 1 word/frame, direct-mapped, read-only).
REQ-002 One clock; reset is asynchronous and active-low; ports named CLK and nRST.
REQ-003 CLK  input  1  system clock, all state updates on rising edge.
REQ-004 nRST  input  1  asynchronous active-low reset.
REQ-005 imemREN  input  1  datapath instruction read request.
REQ-006 imemaddr  input  32  datapath instruction byte address (PC).
REQ-007 ihit  output  1  requested word valid on imemload this cycle.
REQ-008 imemload  output  32  instruction word to datapath.
REQ-009 iREN  output  1  read request to memory controller.
REQ-010 iaddr  output  32  word-aligned memory read address.
REQ-011 iwait  input  1  memory busy; low means iload valid this cycle.
REQ-012 iload  input  32  memory read data.

Function
REQ-013 Address split: tag = imemaddr[31:6] (26 b), index = imemaddr[5:2] (4 b), imemaddr[1:0] ignored.
REQ-014 Each frame holds valid (1 b), tag (26 b), data (32 b).
REQ-015 FSM states: IDLE, MISS.
REQ-016 hit = (state==IDLE) & imemREN & valid[index] & (tag[index]==tag); combinational, zero-cycle.
REQ-017 ihit = hit; imemload = data[index] when hit, else 32'h0.
REQ-018 IDLE: iREN=0, iaddr=0; imemREN & ~hit -> MISS next cycle; otherwise stay.
REQ-019 MISS: iREN=1, iaddr={imemaddr[31:2],2'b00}, ihit=0.
REQ-020 MISS & imemREN & ~iwait: frame[index] <= {1, tag, iload}; -> IDLE; requested word hits on following cycle.
REQ-021 MISS & iwait: stay in MISS, no frame change.
REQ-022 MISS & ~imemREN: abort -> IDLE, no fill, iREN drops next cycle.
REQ-023 imemaddr changing during MISS (redirect): iaddr tracks current imemaddr; fill uses address present on the ~iwait cycle.
REQ-024 Conflict: fill overwrites frame at index unconditionally (replacement of differing tag).
REQ-025 Miss latency: 1 detect cycle + memory wait cycles + hit in next IDLE cycle; hit latency 0 cycles.
REQ-026 iwait, iload ignored while iREN=0.
REQ-027 No writes from datapath side; cache never issues memory writes.

Reset
REQ-028 nRST low: state=IDLE, all valid=0, all tags and data=0, asynchronously.
REQ-029 During/after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-030 Reset asserted mid-MISS discards pending fill; first post-reset request misses.

Structure
REQ-031 Frame struct (icache_frame_t), address-split struct (icachef_t), ITAG_W=26, IIDX_W=4, IFRAMES=16 in cpu_types_pkg.
REQ-032 FSM state enum local to icache.
REQ-033 No sub-module; frame array and FSM inline in icache.

Verification
REQ-034 Cold miss: reset, imemREN=1, imemaddr=0x0000_0004, iwait low after 2 cycles, iload=0x2002_0001 -> iREN=1 with iaddr=0x4 for 3 cycles, then ihit=1, imemload=0x2002_0001 next cycle.
REQ-035 Repeat hit: re-request 0x0000_0004 -> ihit=1 same cycle, iREN=0, imemload=0x2002_0001.
REQ-036 Conflict: fill 0x0000_0040 (index 0) with 0xAAAA_AAAA, then 0x0000_0000 with 0xBBBB_BBBB -> 0x40 misses again afterward; 0x0 hits with 0xBBBB_BBBB.
REQ-037 Abort: miss on 0x0000_0008, drop imemREN while iwait=1 -> IDLE next cycle, iREN=0, later request to 0x8 misses.
REQ-038 Redirect: in MISS change imemaddr 0x10->0x20 before iwait falls, iload=0x1234_5678 -> frame index 8 filled, 0x20 hits, 0x10 misses.
REQ-039 Reset mid-miss: assert nRST=0 during MISS -> iREN=0 immediately, all prior hits now miss.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared instruction-cache geometry, address split and frame layout
//   ITAG_W/IIDX_W/IFRAMES fix a 16-frame, one-word-per-frame, direct-mapped cache.
package cpu_types_pkg;
  localparam int ITAG_W  = 26;
  localparam int IIDX_W  = 4;
  localparam int IFRAMES = 16;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame_t;
endpackage

// File: rtl/icache.sv
// icache: read-only direct-mapped instruction cache, zero-cycle hits, single-word fills
//   CLK/nRST          clock, async active-low reset
//   imemREN/imemaddr  datapath fetch request and byte address
//   ihit/imemload     hit strobe and instruction word (0 when no hit)
//   iREN/iaddr        memory read request and word-aligned address (only in MISS)
//   iwait/iload       memory busy flag and read data
module icache
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  typedef enum logic {IDLE, MISS} state_t;

  state_t        r_state;
  icache_frame_t r_frames [IFRAMES];
  icachef_t      w_addr;
  icache_frame_t w_frame;
  logic          w_hit;

  assign w_addr   = icachef_t'(imemaddr);
  assign w_frame  = r_frames[w_addr.idx];
  assign w_hit    = (r_state == IDLE) && imemREN && w_frame.valid && (w_frame.tag == w_addr.tag);
  assign ihit     = w_hit;
  assign imemload = w_hit ? w_frame.data : 32'h0;
  assign iREN     = (r_state == MISS);
  // iaddr follows the live PC so a redirect during a miss fetches the new target
  assign iaddr    = (r_state == MISS) ? {imemaddr[31:2], 2'b00} : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      for (int i = 0; i < IFRAMES; i++) r_frames[i] <= '0;
    end else if (r_state == IDLE) begin
      if (imemREN && !w_hit) r_state <= MISS;
    end else if (!imemREN) begin
      r_state <= IDLE;
    end else if (!iwait) begin
      r_frames[w_addr.idx] <= '{valid: 1'b1, tag: w_addr.tag, data: iload};
      r_state              <= IDLE;
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed vector table plus hand-written fill/tag sequence for icache
module tb_icache;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;

  int n_chk = 0;
  int n_fail = 0;

  icache dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic        ren;
    logic [31:0] addr;
    logic        iw;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [31:0] a, input logic w, input logic [31:0] l,
                     input logic eh, input logic [31:0] el, input logic er, input logic [31:0] ea);
    vq.push_back('{r, e, a, w, l, eh, el, er, ea});
  endtask

  initial begin
    bit found;
    // rst ren addr iwait iload | ihit imemload iREN iaddr
    add(0, 0, 32'h00, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    // cold miss on 0x4: detect, two wait cycles, fill, then hit
    add(1, 1, 32'h04, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 1, 32'h04, 1, 32'h0,        0, 32'h0,        1, 32'h04);
    add(1, 1, 32'h04, 1, 32'h0,        0, 32'h0,        1, 32'h04);
    add(1, 1, 32'h04, 0, 32'h20020001, 0, 32'h0,        1, 32'h04);
    add(1, 1, 32'h04, 1, 32'hDEADBEEF, 1, 32'h20020001, 0, 32'h00);
    add(1, 1, 32'h04, 0, 32'hDEADBEEF, 1, 32'h20020001, 0, 32'h00);
    // conflict on index 0
    add(1, 1, 32'h40, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 1, 32'h40, 0, 32'hAAAAAAAA, 0, 32'h0,        1, 32'h40);
    add(1, 1, 32'h40, 1, 32'h0,        1, 32'hAAAAAAAA, 0, 32'h00);
    add(1, 1, 32'h00, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 1, 32'h00, 0, 32'hBBBBBBBB, 0, 32'h0,        1, 32'h00);
    add(1, 1, 32'h00, 1, 32'h0,        1, 32'hBBBBBBBB, 0, 32'h00);
    add(1, 1, 32'h40, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 0, 32'h40, 1, 32'h0,        0, 32'h0,        1, 32'h40);
    add(1, 0, 32'h00, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 1, 32'h00, 1, 32'h0,        1, 32'hBBBBBBBB, 0, 32'h00);
    // abort on 0x8, even with iwait low on the abort cycle
    add(1, 1, 32'h08, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 1, 32'h08, 1, 32'h0,        0, 32'h0,        1, 32'h08);
    add(1, 0, 32'h08, 0, 32'h11111111, 0, 32'h0,        1, 32'h08);
    add(1, 0, 32'h08, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 1, 32'h08, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 0, 32'h08, 1, 32'h0,        0, 32'h0,        1, 32'h08);
    // redirect 0x10 -> 0x20 mid-miss
    add(1, 1, 32'h10, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 1, 32'h10, 1, 32'h0,        0, 32'h0,        1, 32'h10);
    add(1, 1, 32'h20, 0, 32'h12345678, 0, 32'h0,        1, 32'h20);
    add(1, 1, 32'h20, 1, 32'h0,        1, 32'h12345678, 0, 32'h00);
    add(1, 1, 32'h10, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 1, 32'h13, 1, 32'h0,        0, 32'h0,        1, 32'h10);
    // reset mid-miss discards everything
    add(0, 1, 32'h10, 0, 32'h55555555, 0, 32'h0,        0, 32'h00);
    add(1, 1, 32'h04, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 0, 32'h04, 1, 32'h0,        0, 32'h0,        1, 32'h04);
    add(1, 1, 32'h20, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 0, 32'h20, 1, 32'h0,        0, 32'h0,        1, 32'h20);
    add(1, 1, 32'h00, 1, 32'h0,        0, 32'h0,        0, 32'h00);
    add(1, 0, 32'h00, 1, 32'h0,        0, 32'h0,        1, 32'h00);

    foreach (vq[i]) begin
      @(negedge CLK);
      nRST = vq[i].rst_n; imemREN = vq[i].ren; imemaddr = vq[i].addr;
      iwait = vq[i].iw; iload = vq[i].ld;
      #2;
      chk("ihit", i, {31'b0, ihit}, {31'b0, vq[i].e_hit});
      chk("imemload", i, imemload, vq[i].e_load);
      chk("iREN", i, {31'b0, iREN}, {31'b0, vq[i].e_iren});
      chk("iaddr", i, iaddr, vq[i].e_iaddr);
    end

    // memory answers immediately: hit must arrive within a bounded number of cycles
    @(negedge CLK);
    imemREN = 1; imemaddr = 32'h04; iwait = 0; iload = 32'hCAFEF00D;
    found = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      #2;
      if (ihit) found = 1; else @(negedge CLK);
    end
    chk("fill_hit_seen", 100, {31'b0, found}, 32'd1);
    chk("fill_hit_load", 100, imemload, 32'hCAFEF00D);
    // same index, tag differs only in the MSB: must miss
    @(negedge CLK);
    imemaddr = 32'h80000004; iwait = 1;
    #2;
    chk("msb_tag_hit", 101, {31'b0, ihit}, 32'd0);
    chk("msb_tag_load", 101, imemload, 32'h0);
    @(negedge CLK);
    #2;
    chk("msb_tag_iaddr", 102, iaddr, 32'h80000004);
    imemREN = 0;
    @(negedge CLK);
    imemREN = 1; imemaddr = 32'h04;
    #2;
    chk("orig_tag_hit", 103, imemload, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
